fifo_param: RTL and testbench

Parametrised successor to the team's 6-bit FIFO: a synchronous single-clock FIFO with configurable data width and depth, almost-full/almost-empty thresholds, an occupancy count, a registered read port with a one-cycle valid strobe, and a sticky, clearable overflow/underflow error. It sits between a producer and a consumer on the data path and replaces fixed-size FIFO instances. The default parameters reproduce the 6-bit data path.

---
 rtl/fifo_param_pkg.sv | 17 +
 rtl/fifo_mem.sv | 24 ++
 rtl/fifo_param.sv | 109 ++++++++++
 tb/tb_fifo_param.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fifo_param_pkg.sv
// fifo_param shared definitions.
// Default geometry and the per-cycle request bundle.
package fifo_param_pkg;

  localparam int DATA_W_D    = 6;
  localparam int ADDR_W_D    = 3;
  localparam int AFULL_TH_D  = 6;
  localparam int AEMPTY_TH_D = 2;

  typedef struct packed {
    logic wr_acc;
    logic rd_acc;
    logic ovf;
    logic udf;
  } fifo_req_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_param storage array.
// One sync write port, one sync read port, no reset.
module fifo_mem #(
  parameter int DW = 6,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];

  // write stores the word; read returns the pre-write contents
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/fifo_param.sv
// fifo_param top: pointers, count, flags,
// sticky error and the registered read port.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int DATA_W    = DATA_W_D,
  parameter int ADDR_W    = ADDR_W_D,
  parameter int AFULL_TH  = AFULL_TH_D,
  parameter int AEMPTY_TH = AEMPTY_TH_D
) (
  input  logic              clk,
  input  logic              RESET_L,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_wr,
  input  logic              fifo_rd,
  input  logic              err_clr,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              err_fifo
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = CW'(2**ADDR_W);
  localparam logic [ADDR_W:0] AF_C = CW'(AFULL_TH);
  localparam logic [ADDR_W:0] AE_C = CW'(AEMPTY_TH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_valid;
  logic              r_loaded;
  logic              r_err;
  logic [DATA_W-1:0] w_mem_q;
  fifo_req_t         w_req;

  // decode accepted and illegal requests
  always_comb begin
    w_req        = '0;
    w_req.rd_acc = fifo_rd & ~fifo_empty;
    w_req.wr_acc = fifo_wr & (~fifo_full | fifo_rd);
    w_req.ovf    = fifo_wr & fifo_full & ~fifo_rd;
    w_req.udf    = fifo_rd & fifo_empty;
  end

  fifo_mem #(
    .DW (DATA_W),
    .AW (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_req.wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_re    (w_req.rd_acc),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_q)
  );

  // pointers and occupancy
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_req.wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_req.rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count
               + {{ADDR_W{1'b0}}, w_req.wr_acc}
               - {{ADDR_W{1'b0}}, w_req.rd_acc};
    end
  end

  // read strobe; r_loaded masks the unreset array output
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      r_valid  <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_valid <= w_req.rd_acc;
      if (w_req.rd_acc) r_loaded <= 1'b1;
    end
  end

  // sticky error: a new error beats a same-cycle clear
  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      r_err <= 1'b0;
    end else if (w_req.ovf | w_req.udf) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign data_out     = r_loaded ? w_mem_q : '0;
  assign valid_out    = r_valid;
  assign fifo_count   = r_count;
  assign fifo_empty   = (r_count == '0);
  assign fifo_full    = (r_count == DEPTH_C);
  assign almost_empty = (r_count <= AE_C);
  assign almost_full  = (r_count >= AF_C);
  assign err_fifo     = r_err;

endmodule

// File: tb/tb_fifo_param.sv
// fifo_param bench: directed scenarios then
// random traffic against a queue model.
module tb_fifo_param;

  localparam int DW    = 6;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 2;

  logic          clk = 1'b0;
  logic          RESET_L;
  logic [DW-1:0] data_in;
  logic          fifo_wr;
  logic          fifo_rd;
  logic          err_clr;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic          fifo_empty;
  logic          fifo_full;
  logic          almost_empty;
  logic          almost_full;
  logic [AW:0]   fifo_count;
  logic          err_fifo;

  fifo_param dut (
    .clk          (clk),
    .RESET_L      (RESET_L),
    .data_in      (data_in),
    .fifo_wr      (fifo_wr),
    .fifo_rd      (fifo_rd),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .fifo_count   (fifo_count),
    .err_fifo     (err_fifo)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_valid;
  logic          m_err;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    int n;
    n = q.size();
    chk("count", 32'(fifo_count), 32'(n));
    chk("empty", 32'(fifo_empty), 32'(n == 0));
    chk("full", 32'(fifo_full), 32'(n == DEPTH));
    chk("aempty", 32'(almost_empty), 32'(n <= AET));
    chk("afull", 32'(almost_full), 32'(n >= AFT));
    chk("dout", 32'(data_out), 32'(m_dout));
    chk("valid", 32'(valid_out), 32'(m_valid));
    chk("err", 32'(err_fifo), 32'(m_err));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // one clock: drive, apply the queue rules, check
  task automatic step(input logic wr, input logic rd,
                      input logic [DW-1:0] d,
                      input logic clr);
    bit emp, ful, ra, wa;
    fifo_wr = wr;
    fifo_rd = rd;
    data_in = d;
    err_clr = clr;
    @(posedge clk);
    emp = (q.size() == 0);
    ful = (q.size() == DEPTH);
    ra  = rd && !emp;
    wa  = wr && (!ful || rd);
    if ((wr && ful && !rd) || (rd && emp)) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    m_valid = ra;
    if (ra) m_dout = q.pop_front();
    if (wa) q.push_back(d);
    #1;
    chk_all();
  endtask

  initial begin
    RESET_L = 1'b0;
    fifo_wr = 1'b0;
    fifo_rd = 1'b0;
    err_clr = 1'b0;
    data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 RESET_L = 1'b1;
    chk_all();
    step(0, 0, 0, 0);

    for (int i = 1; i <= 8; i++) step(1, 0, DW'(i), 0);
    chk("full8", 32'(fifo_full), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0);
      chk("rd_order", 32'(data_out), 32'(i));
    end
    chk("empty_after", 32'(fifo_empty), 32'd1);

    for (int i = 1; i <= 8; i++) step(1, 0, DW'(i), 0);
    step(1, 1, 6'h2A, 0);
    chk("rw_full_cnt", 32'(fifo_count), 32'd8);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    chk("wrap_last", 32'(data_out), 32'h2A);

    for (int i = 0; i < 8; i++) step(1, 0, DW'(i + 16), 0);
    step(1, 0, 6'h3F, 0);
    chk("ovf_err", 32'(err_fifo), 32'd1);
    step(0, 0, 0, 1);
    chk("clr_err", 32'(err_fifo), 32'd0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("udf_valid", 32'(valid_out), 32'd0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    chk("clr_vs_udf", 32'(err_fifo), 32'd1);
    step(1, 1, 6'h05, 0);
    chk("empty_rw_cnt", 32'(fifo_count), 32'd1);
    step(0, 1, 0, 1);

    for (int i = 0; i < 3; i++) step(1, 0, DW'(i + 9), 0);
    #3 RESET_L = 1'b0;
    #1 model_reset();
    chk_all();
    #1 RESET_L = 1'b1;
    step(1, 0, 6'h15, 0);
    step(0, 1, 0, 0);
    chk("post_rst", 32'(data_out), 32'h15);

    for (int i = 0; i < 3000; i++) begin
      int pw;
      pw = ((i / 200) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 99) < pw,
           $urandom_range(0, 99) < 50,
           DW'($urandom),
           $urandom_range(0, 99) < 10);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
